// File: rtl/int_controller.sv
// int_controller: 16-line prioritised interrupt controller with mask, pending,
// edge/level selection and an IDLE/REQ/SERVICE handshake with the CPU.
module int_controller #(
   parameter logic [15:0] VECTOR_BASE = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] irq_in,
   input  logic        write,
   input  logic        read,
   input  logic [1:0]  sel,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   input  logic        ack,
   input  logic        eoi,
   output logic        interrupt,
   output logic [15:0] int_addr,
   output logic        in_service
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
   state_t      r_state, w_next;
   logic [15:0] r_irq_q, r_mask, r_pending, r_edge;
   logic [15:0] w_active, w_set, w_clr;
   logic [3:0]  r_vec, w_low;
   logic        w_take;
   assign w_active = r_pending & r_mask;
   assign w_set    = irq_in & (~r_edge | ~r_irq_q);
   assign w_take   = (r_state == REQ) && ack;
   assign w_clr    = ((write && sel == 2'd1) ? wr_data : 16'h0000) | (w_take ? 16'h0001 << r_vec : 16'h0000);
   // Scan high to low so the lowest active index ends up winning.
   always_comb begin
      w_low = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (w_active[i]) w_low = 4'(i);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_q   <= '0;
         r_mask    <= '0;
         r_pending <= '0;
         r_edge    <= '0;
      end else begin
         r_irq_q   <= irq_in;
         r_pending <= (r_pending & ~w_clr) | w_set;
         if (write && sel == 2'd0) r_mask <= wr_data;
         if (write && sel == 2'd3) r_edge <= wr_data;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_vec   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && |w_active) r_vec <= w_low;
      end
   end
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = |w_active ? REQ : IDLE;
         REQ:     w_next = ack ? SERVICE : (w_active[r_vec] ? REQ : IDLE);
         SERVICE: w_next = eoi ? IDLE : SERVICE;
         default: w_next = IDLE;
      endcase
   end
   always_comb begin
      interrupt  = r_state == REQ;
      in_service = r_state == SERVICE;
      int_addr   = interrupt ? VECTOR_BASE + {12'h000, r_vec} : 16'h0000;
      rd_data    = !read ? 16'h0000 :
                   sel == 2'd0 ? r_mask :
                   sel == 2'd1 ? r_pending :
                   sel == 2'd2 ? {interrupt, in_service, 10'b0, r_vec} : r_edge;
   end
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed stimulus queues expected snapshots; a negedge
// monitor pops and compares them whenever a read strobe is presented.
module tb_int_controller;
   logic        clk, rst, write, read, ack, eoi;
   logic [1:0]  sel;
   logic [15:0] irq_in, wr_data, rd_data, int_addr;
   logic        interrupt, in_service;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      string       name;
      logic        e_int;
      logic [15:0] e_addr;
      logic        e_ins;
      logic [15:0] e_rd;
   } exp_t;
   exp_t q[$];
   exp_t m_e;

   int_controller #(.VECTOR_BASE(16'hFFFC)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .write(write), .read(read),
      .sel(sel), .wr_data(wr_data), .rd_data(rd_data), .ack(ack), .eoi(eoi),
      .interrupt(interrupt), .int_addr(int_addr), .in_service(in_service)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   always @(negedge clk) begin
      checks++;
      if (read) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: no expectation queued");
         end else begin
            m_e = q.pop_front();
            if (interrupt !== m_e.e_int || int_addr !== m_e.e_addr || in_service !== m_e.e_ins || rd_data !== m_e.e_rd) begin
               errors++;
               $display("FAIL %s: got int=%b addr=%h ins=%b rd=%h, need int=%b addr=%h ins=%b rd=%h",
                        m_e.name, interrupt, int_addr, in_service, rd_data, m_e.e_int, m_e.e_addr, m_e.e_ins, m_e.e_rd);
            end
         end
      end else if (rd_data !== 16'h0000) begin
         errors++;
         $display("FAIL rd_idle: got rd=%h, need rd=0000", rd_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] s, input logic [15:0] d);
      sel = s;
      wr_data = d;
      write = 1;
      tick();
      write = 0;
   endtask

   task automatic probe(input string n, input logic [1:0] s, input logic ei, input logic [15:0] ea,
                        input logic es, input logic [15:0] er);
      exp_t e;
      e.name = n;
      e.e_int = ei;
      e.e_addr = ea;
      e.e_ins = es;
      e.e_rd = er;
      q.push_back(e);
      sel = s;
      read = 1;
      @(negedge clk);
      #1;
      read = 0;
   endtask

   initial begin
      rst = 1; write = 0; read = 0; ack = 0; eoi = 0; sel = 0; irq_in = 0; wr_data = 0;
      repeat (2) tick();
      probe("rst_mask", 2'd0, 0, 16'h0000, 0, 16'h0000);
      probe("rst_status", 2'd2, 0, 16'h0000, 0, 16'h0000);
      rst = 0;
      tick();
      wr(2'd0, 16'h0004);
      wr(2'd3, 16'h0004);
      irq_in = 16'h0004; tick(); irq_in = 0;
      probe("edge_pend", 2'd1, 0, 16'h0000, 0, 16'h0004);
      tick();
      probe("edge_req", 2'd2, 1, 16'hFFFE, 0, 16'h8002);
      ack = 1; tick(); ack = 0;
      probe("edge_ack", 2'd1, 0, 16'h0000, 1, 16'h0000);
      eoi = 1; tick(); eoi = 0;
      probe("edge_eoi", 2'd2, 0, 16'h0000, 0, 16'h0002);
      wr(2'd3, 16'h0000);
      wr(2'd0, 16'hFFFF);
      irq_in = 16'h0028; tick(); tick();
      probe("prio_first", 2'd2, 1, 16'hFFFF, 0, 16'h8003);
      irq_in = 16'h0020; ack = 1; tick(); ack = 0;
      probe("prio_ack", 2'd1, 0, 16'h0000, 1, 16'h0020);
      eoi = 1; tick(); eoi = 0; tick();
      probe("prio_second", 2'd2, 1, 16'h0001, 0, 16'h8005);
      irq_in = 16'h0022; tick(); tick();
      probe("freeze_addr", 2'd2, 1, 16'h0001, 0, 16'h8005);
      probe("freeze_pend", 2'd1, 1, 16'h0001, 0, 16'h0022);
      irq_in = 16'h0002; ack = 1; tick(); ack = 0;
      eoi = 1; tick(); eoi = 0; tick();
      probe("freeze_next", 2'd2, 1, 16'hFFFD, 0, 16'h8001);
      irq_in = 0; ack = 1; tick(); ack = 0;
      eoi = 1; tick(); eoi = 0;
      irq_in = 16'h0004; tick(); irq_in = 0; tick();
      probe("wd_req", 2'd2, 1, 16'hFFFE, 0, 16'h8002);
      wr(2'd1, 16'h0004);
      probe("wd_cleared", 2'd1, 1, 16'hFFFE, 0, 16'h0000);
      tick();
      probe("wd_idle", 2'd2, 0, 16'h0000, 0, 16'h0002);
      irq_in = 16'h0010; tick(); tick();
      probe("lvl_req", 2'd2, 1, 16'h0000, 0, 16'h8004);
      eoi = 1; tick(); eoi = 0;
      probe("eoi_ignored", 2'd2, 1, 16'h0000, 0, 16'h8004);
      ack = 1; tick(); ack = 0;
      probe("lvl_repend", 2'd1, 0, 16'h0000, 1, 16'h0010);
      ack = 1; tick(); ack = 0;
      probe("ack_ignored", 2'd2, 0, 16'h0000, 1, 16'h4004);
      eoi = 1; tick(); eoi = 0;
      probe("lvl_eoi", 2'd2, 0, 16'h0000, 0, 16'h0004);
      tick();
      probe("lvl_again", 2'd2, 1, 16'h0000, 0, 16'h8004);
      ack = 1; tick(); ack = 0;
      probe("svc", 2'd2, 0, 16'h0000, 1, 16'h4004);
      tick();
      rst = 1;
      probe("rst_async", 2'd0, 0, 16'h0000, 0, 16'h0000);
      probe("rst_pend", 2'd1, 0, 16'h0000, 0, 16'h0000);
      rst = 0;
      tick();
      probe("post_rst_pend", 2'd1, 0, 16'h0000, 0, 16'h0010);
      irq_in = 0;
      wr(2'd1, 16'hFFFF);
      wr(2'd3, 16'h0001);
      irq_in = 16'h0001; tick(); tick();
      probe("edge_hold_set", 2'd1, 0, 16'h0000, 0, 16'h0001);
      wr(2'd1, 16'h0001);
      tick();
      probe("edge_hold", 2'd1, 0, 16'h0000, 0, 16'h0000);
      wr(2'd2, 16'hFFFF);
      probe("sel2_ignored", 2'd0, 0, 16'h0000, 0, 16'h0000);
      probe("edge_mode_rd", 2'd3, 0, 16'h0000, 0, 16'h0001);
      tick();
      if (q.size() != 0) begin
         errors += q.size();
         $display("FAIL scoreboard_drain: got %0d left, need 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
